// File: rtl/nano_cpu_pkg.sv
// nano_cpu_pkg: shared opcode/funct3 constants and FSM state encoding
package nano_cpu_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
    function automatic logic is_shift(input logic [2:0] f3);
        return f3 == F3_SLL || f3 == F3_SRL;
    endfunction
endpackage

// File: rtl/nano_regfile.sv
// nano_regfile: 32x32 register file, two read ports plus debug port, x0 reads zero
module nano_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] dbg_data
);
    logic [31:0] mem [32];
    // synchronous write, x0 never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata1   = raddr1   == '0 ? '0 : mem[raddr1];
    assign rdata2   = raddr2   == '0 ? '0 : mem[raddr2];
    assign dbg_data = dbg_addr == '0 ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes RV32 ALU instructions, issues them to the ALU and writes results back
module alu_issue_ctrl
    import nano_cpu_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        alu_r_i_s,
    output logic [2:0]  alu_funct3,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_in_valid,
    input  logic [31:0] alu_out,
    input  logic        alu_out_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal_err,
    output logic        timeout_err,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    localparam int CW = $clog2(TIMEOUT);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [4:0] rd_q;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [31:0] rd1, rd2, dec_a, dec_b;
    logic xfer, legal, we, timed_out, is_op, is_opi, is_lui;
    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign instr_ready = state == S_IDLE;
    assign xfer = instr_valid && instr_ready;
    assign we = state == S_WAIT && alu_out_valid;
    assign timed_out = state == S_WAIT && !alu_out_valid && cnt == CW'(TIMEOUT - 1);
    nano_regfile u_rf (
        .clk(clk), .rst(rst), .we(we), .waddr(rd_q), .wdata(alu_out),
        .raddr1(instr[19:15]), .raddr2(instr[24:20]), .dbg_addr(dbg_addr),
        .rdata1(rd1), .rdata2(rd2), .dbg_data(dbg_data)
    );
    // decode: legality and operand selection; shifts only ever see a 5-bit amount
    always_comb begin
        is_op  = opc == OPC_OP && f7 == '0 && (f3 == F3_ADD || f3 == F3_AND || is_shift(f3));
        is_opi = opc == OPC_OP_IMM && (f3 == F3_ADD || f3 == F3_AND || (is_shift(f3) && f7 == '0));
        is_lui = opc == OPC_LUI;
        legal  = is_op || is_opi || is_lui;
        dec_a  = is_lui ? '0 : rd1;
        dec_b  = is_lui ? {instr[31:12], 12'b0} :
                 is_op  ? (is_shift(f3) ? {27'b0, rd2[4:0]} : rd2) :
                          (is_shift(f3) ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]});
    end
    // next state: illegal instructions are consumed without leaving IDLE
    always_comb begin
        state_n = state == S_IDLE  ? (xfer && legal ? S_ISSUE : S_IDLE) :
                  state == S_ISSUE ? S_WAIT :
                  (we || timed_out) ? S_IDLE : S_WAIT;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end
    // registered outputs; funct3/r_i_s only change on a transfer so they hold through WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_r_i_s    <= 1'b0;
            alu_funct3   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_in_valid <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            illegal_err  <= 1'b0;
            timeout_err  <= 1'b0;
            rd_q         <= '0;
            cnt          <= '0;
        end else begin
            alu_in_valid <= xfer && legal;
            illegal_err  <= xfer && !legal;
            timeout_err  <= timed_out;
            wb_valid     <= we;
            wb_rd        <= we ? rd_q : '0;
            wb_data      <= we ? alu_out : '0;
            cnt          <= state == S_WAIT ? cnt + 1'b1 : '0;
            if (xfer && legal) begin
                alu_a      <= dec_a;
                alu_b      <= dec_b;
                alu_funct3 <= is_lui ? F3_ADD : f3;
                alu_r_i_s  <= !is_lui;
                rd_q       <= instr[11:7];
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scoreboard bench with a behavioural 2-cycle ALU stub
module tb_alu_issue_ctrl;
    logic clk = 0, rst = 1;
    logic [31:0] instr = '0;
    logic instr_valid = 0;
    logic instr_ready, alu_r_i_s, alu_in_valid, alu_out_valid, wb_valid, illegal_err, timeout_err;
    logic [2:0] alu_funct3;
    logic [31:0] alu_a, alu_b, alu_out, wb_data, dbg_data;
    logic [4:0] wb_rd, dbg_addr = '0;
    logic alu_en = 1, stray = 0, st1 = 0, ov_q = 0;
    logic [31:0] a_q = '0, b_q = '0, out_q = '0;
    int checks = 0, errors = 0, lat, waits;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    wb_t sb[$];
    wb_t e;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .alu_r_i_s(alu_r_i_s), .alu_funct3(alu_funct3), .alu_a(alu_a), .alu_b(alu_b),
        .alu_in_valid(alu_in_valid), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal_err(illegal_err),
        .timeout_err(timeout_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, b, input logic [2:0] f3, input logic ris);
        if (!ris) return a + b;
        case (f3)
            3'b000:  return a + b;
            3'b001:  return a << b[4:0];
            3'b101:  return a >> b[4:0];
            3'b111:  return a & b;
            default: return '0;
        endcase
    endfunction

    // ALU stub: operands captured on in_valid, result valid two edges later, funct3/r_i_s used live
    always @(posedge clk) begin
        st1 <= alu_in_valid && alu_en;
        if (alu_in_valid) begin
            a_q <= alu_a;
            b_q <= alu_b;
        end
        ov_q  <= st1;
        out_q <= alu_model(a_q, b_q, alu_funct3, alu_r_i_s);
    end
    assign alu_out_valid = ov_q | stray;
    assign alu_out = stray ? 32'hDEADBEEF : out_q;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write-back must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed rd=%0d data=%0h expected=none", wb_rd, wb_data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (wb_rd === e.rd && wb_data === e.data) else begin
                    errors++;
                    $error("FAIL wb_data observed rd=%0d data=%0h expected rd=%0d data=%0h", wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic issue(input string tag, input logic [31:0] i, input logic [31:0] ea, eb,
                         input logic [2:0] ef3, input logic eris, input logic [4:0] erd, input logic [31:0] ed);
        sb.push_back('{erd, ed});
        instr = i;
        instr_valid = 1;
        @(negedge clk);
        instr_valid = 0;
        chk({tag, "_in_valid"}, alu_in_valid, 1);
        chk({tag, "_ready_low"}, instr_ready, 0);
        chk({tag, "_a"}, alu_a, ea);
        chk({tag, "_b"}, alu_b, eb);
        chk({tag, "_f3"}, alu_funct3, ef3);
        chk({tag, "_ris"}, alu_r_i_s, eris);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wb_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 3);
    endtask

    task automatic dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic illegal(input string tag, input logic [31:0] i);
        instr = i;
        instr_valid = 1;
        @(negedge clk);
        instr_valid = 0;
        chk({tag, "_err"}, illegal_err, 1);
        chk({tag, "_no_issue"}, alu_in_valid, 0);
        chk({tag, "_ready"}, instr_ready, 1);
        @(negedge clk);
        chk({tag, "_err_pulse"}, illegal_err, 0);
    endtask

    task automatic send_b2b(input logic [31:0] i, input logic [4:0] erd, input logic [31:0] ed, output int w);
        sb.push_back('{erd, ed});
        instr = i;
        instr_valid = 1;
        w = -1;
        for (int k = 0; k < 20; k++) begin
            if (instr_ready) begin
                w = k;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outs", {alu_r_i_s, alu_funct3, alu_a, alu_b, alu_in_valid, wb_valid, wb_rd, wb_data, illegal_err, timeout_err}, '0);
        chk("reset_ready", instr_ready, 1);
        rst = 0;
        @(negedge clk);
        dbg("reset_x1", 5'd1, 32'd0);

        issue("addi", 32'h00500093, 32'd0, 32'd5, 3'b000, 1'b1, 5'd1, 32'd5);
        dbg("dbg_x1", 5'd1, 32'd5);
        issue("slli", 32'h00309113, 32'd5, 32'd3, 3'b001, 1'b1, 5'd2, 32'd40);
        issue("addi_x5", 32'h02300293, 32'd0, 32'h23, 3'b000, 1'b1, 5'd5, 32'h23);
        issue("sll_mask", 32'h00509333, 32'd5, 32'd3, 3'b001, 1'b1, 5'd6, 32'd40);
        issue("lui", 32'h123451B7, 32'd0, 32'h12345000, 3'b000, 1'b0, 5'd3, 32'h12345000);
        issue("andi_neg", 32'hFFF1F393, 32'h12345000, 32'hFFFFFFFF, 3'b111, 1'b1, 5'd7, 32'h12345000);
        issue("srl", 32'h0051D433, 32'h12345000, 32'd3, 3'b101, 1'b1, 5'd8, 32'h02468A00);
        issue("addi_x0", 32'h00108013, 32'd5, 32'd1, 3'b000, 1'b1, 5'd0, 32'd6);
        dbg("dbg_x0", 5'd0, 32'd0);
        dbg("dbg_x6", 5'd6, 32'd40);

        illegal("sub", 32'h40208233);
        illegal("slt", 32'h0020A233);
        illegal("slli_bad", 32'h02009113);
        dbg("sub_x4", 5'd4, 32'd0);
        dbg("slli_bad_x2", 5'd2, 32'd40);

        alu_en = 0;
        instr = 32'h00707493;
        instr_valid = 1;
        @(negedge clk);
        instr_valid = 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("wait_f3_hold", alu_funct3, 3'b111);
                chk("wait_in_valid_low", alu_in_valid, 0);
            end
            if (timeout_err) begin
                lat = k;
                break;
            end
        end
        chk("timeout_cycles", lat, 9);
        chk("timeout_ready", instr_ready, 1);
        @(negedge clk);
        chk("timeout_pulse", timeout_err, 0);
        dbg("timeout_x9", 5'd9, 32'd0);
        alu_en = 1;

        instr = 32'h00900513;
        instr_valid = 1;
        @(negedge clk);
        instr_valid = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("midrst_outs", {alu_r_i_s, alu_funct3, alu_a, alu_b, alu_in_valid, wb_valid, wb_rd, wb_data, illegal_err, timeout_err}, '0);
        chk("midrst_ready", instr_ready, 1);
        dbg("midrst_x1", 5'd1, 32'd0);
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        dbg("midrst_x10", 5'd10, 32'd0);
        stray = 1;
        @(negedge clk);
        stray = 0;
        chk("stray_no_err", timeout_err, 0);
        @(negedge clk);
        dbg("stray_x0", 5'd0, 32'd0);

        send_b2b(32'h00100593, 5'd11, 32'd1, waits);
        chk("b2b_first", waits, 0);
        send_b2b(32'h00258613, 5'd12, 32'd3, waits);
        chk("b2b_second_gap", waits, 3);
        send_b2b(32'h00C586B3, 5'd13, 32'd4, waits);
        chk("b2b_third_gap", waits, 3);
        instr_valid = 0;
        repeat (6) @(negedge clk);
        dbg("b2b_x13", 5'd13, 32'd4);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
